// File: rtl/pipeline_dot2.sv
// Three-stage pipelined unsigned dot product: C = A1*B1 + A2*B2, one result per clock.
// Optional saturation of the final sum is enabled by defining PIPELINE_DOT2_SAT_EN.
module pipeline_dot2 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] B1,
  input  logic [WIDTH-1:0] B2,
  input  logic             in_valid,
  output logic [WIDTH-1:0] C,
  output logic             out_valid
);

  localparam int unsigned P_W = 2 * WIDTH;
  localparam int unsigned S_W = 2 * WIDTH + 1;

  // Stage 1: operand capture
  logic [WIDTH-1:0] a1_q, a1_d, a2_q, a2_d, b1_q, b1_d, b2_q, b2_d;
  logic             v1_q, v1_d;
  // Stage 2: full-width products
  logic [P_W-1:0]   p1_q, p1_d, p2_q, p2_d;
  logic             v2_q, v2_d;
  // Stage 3: result
  logic [WIDTH-1:0] c_q, c_d;
  logic             ov_q, ov_d;
  logic [S_W-1:0]   sum;

  always_comb begin
    a1_d = A1;
    a2_d = A2;
    b1_d = B1;
    b2_d = B2;
    v1_d = in_valid;

    p1_d = P_W'(a1_q) * P_W'(b1_q);
    p2_d = P_W'(a2_q) * P_W'(b2_q);
    v2_d = v1_q;

    sum  = S_W'(p1_q) + S_W'(p2_q);
    c_d  = c_q;
    ov_d = v2_q;
    // C only loads on a valid stage-2 entry, so bubbles hold the last result
    if (v2_q) begin
`ifdef PIPELINE_DOT2_SAT_EN
      if (|sum[S_W-1:WIDTH]) c_d = '1;
      else                   c_d = sum[WIDTH-1:0];
`else
      c_d = WIDTH'(sum);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a1_q <= '0;
      a2_q <= '0;
      b1_q <= '0;
      b2_q <= '0;
      v1_q <= 1'b0;
      p1_q <= '0;
      p2_q <= '0;
      v2_q <= 1'b0;
      c_q  <= '0;
      ov_q <= 1'b0;
    end else begin
      a1_q <= a1_d;
      a2_q <= a2_d;
      b1_q <= b1_d;
      b2_q <= b2_d;
      v1_q <= v1_d;
      p1_q <= p1_d;
      p2_q <= p2_d;
      v2_q <= v2_d;
      c_q  <= c_d;
      ov_q <= ov_d;
    end
  end

  assign C         = c_q;
  assign out_valid = ov_q;

endmodule

// File: tb/tb_pipeline_dot2.sv
// Scoreboard bench for pipeline_dot2: every clocked input set is queued with its
// expected result and checked three edges later against C/out_valid.
module tb_pipeline_dot2;

  localparam int unsigned WIDTH = 32;
  localparam logic [WIDTH-1:0] MAXV = '1;

  logic             clk;
  logic             rst_n;
  logic [WIDTH-1:0] A1, A2, B1, B2;
  logic             in_valid;
  logic [WIDTH-1:0] C;
  logic             out_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic             v;
    logic [WIDTH-1:0] c;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] last_c = '0;

  pipeline_dot2 #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .A1       (A1),
    .A2       (A2),
    .B1       (B1),
    .B2       (B2),
    .in_valid (in_valid),
    .C        (C),
    .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                          input logic [WIDTH-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [WIDTH-1:0] a1, a2, b1, b2);
    logic [2*WIDTH:0] s;
    s = ({{(WIDTH+1){1'b0}}, a1} * {{(WIDTH+1){1'b0}}, b1})
      + ({{(WIDTH+1){1'b0}}, a2} * {{(WIDTH+1){1'b0}}, b2});
`ifdef PIPELINE_DOT2_SAT_EN
    if (s > {{(WIDTH+1){1'b0}}, MAXV}) return MAXV;
`endif
    return s[WIDTH-1:0];
  endfunction

  // Record what the DUT samples on each edge out of reset
  always @(posedge clk) begin
    if (rst_n) sb.push_back('{v: in_valid, c: model(A1, A2, B1, B2)});
  end

  // Entry from edge N must be on the outputs after edge N+2
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      sb.delete();
      last_c = '0;
    end else if (sb.size() > 2) begin
      e = sb.pop_front();
      check_eq("out_valid", {{(WIDTH-1){1'b0}}, out_valid}, {{(WIDTH-1){1'b0}}, e.v});
      if (e.v) last_c = e.c;
      check_eq("C", C, last_c);
    end
  end

  task automatic drive(input logic [WIDTH-1:0] a1, a2, b1, b2, input logic v);
    @(negedge clk);
    A1 = a1; A2 = a2; B1 = b1; B2 = b2; in_valid = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive('0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    A1 = '0; A2 = '0; B1 = '0; B2 = '0; in_valid = 1'b0;
    #100;
    check_eq("reset_C", C, '0);
    check_eq("reset_valid", {{(WIDTH-1){1'b0}}, out_valid}, '0);
    rst_n = 1'b1;
    idle(3);

    // single op -> 3
    drive(0, 1, 2, 3, 1'b1);
    idle(4);

    // back-to-back -> 3, 3
    drive(0, 1, 2, 3, 1'b1);
    drive(3, 2, 1, 0, 1'b1);
    idle(4);

    // bubble with non-zero operands on the invalid cycle -> 2, hold, 83
    drive(1, 1, 1, 1, 1'b1);
    drive(9, 9, 9, 9, 1'b0);
    drive(5, 6, 7, 8, 1'b1);
    idle(4);

    // overflow: wrap gives 2, saturation gives all ones
    drive(MAXV, MAXV, MAXV, MAXV, 1'b1);
    drive(MAXV, 0, 1, 0, 1'b1);
    drive(0, 0, MAXV, MAXV, 1'b1);
    idle(4);

    for (int i = 0; i < 24; i++)
      drive($urandom, $urandom, $urandom, $urandom, 1'($urandom_range(0, 1)));
    idle(4);

    // mid-flight asynchronous reset with two ops in the pipe
    drive(1, 1, 1, 1, 1'b1);
    idle(3);
    drive(5, 6, 7, 8, 1'b1);
    drive(0, 1, 2, 3, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("async_rst_C", C, '0);
    check_eq("async_rst_valid", {{(WIDTH-1){1'b0}}, out_valid}, '0);
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    idle(6);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1);
  end

endmodule
